// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single scalar register-file write port among NUM_REQ functional
// unit writeback requesters (ALU, branch, LSU, MLS, GEMM-status). A
// round-robin pointer picks the winner. The winner is captured into a
// one-entry output stage that drives the scoreboard writeback path.
//
// Behaviour summary:
//   - Back-pressure: while the scoreboard holds off (wb_ready=0), the output
//     stage holds its entry and no requester is granted.
//   - Branch-miss flush: squashes a held entry whose source FU is in
//     flush_mask. It also makes masked requesters ineligible in that cycle.
//   - x0 writes are consumed without producing a write.
//
// Ports:
//   CLK, RST    clock, synchronous active-high reset
//   req_valid   per-FU writeback request
//   req_rd      per-FU destination register, FU i at [i*REG_W +: REG_W]
//   req_data    per-FU write data, FU i at [i*DATA_W +: DATA_W]
//   req_ready   per-FU grant, combinational, one-hot or zero
//   flush       single-cycle branch-miss squash
//   flush_mask  FUs whose results are squashed while flush=1
//   wb_valid    write request to scoreboard/regfile
//   wb_ready    scoreboard accepts the write this cycle
//   wb_rd       destination register of the current write
//   wb_data     data of the current write
//   wb_fu       one-hot source FU of the current write
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
   parameter int NUM_REQ = 5,
   parameter int REG_W   = 5,
   parameter int DATA_W  = 32
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*REG_W-1:0]  req_rd,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      flush,
   input  logic [NUM_REQ-1:0]        flush_mask,
   output logic                      wb_valid,
   input  logic                      wb_ready,
   output logic [REG_W-1:0]          wb_rd,
   output logic [DATA_W-1:0]         wb_data,
   output logic [NUM_REQ-1:0]        wb_fu
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

   // Index reached by stepping ofs places past base, wrapping modulo NUM_REQ.
   // ofs is always below NUM_REQ, so a single conditional subtract suffices.
   function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                 input int unsigned      ofs);
      int unsigned sum;
      sum = int'(base) + ofs;
      if (sum >= unsigned'(NUM_REQ)) begin
         sum = sum - unsigned'(NUM_REQ);
      end else begin
         sum = sum;
      end
      return sum[PTR_W-1:0];
   endfunction

   // One-hot FU vector for an index.
   function automatic logic [NUM_REQ-1:0] fu_onehot(input logic [PTR_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         v[i] = (PTR_W'(i) == idx);
      end
      return v;
   endfunction

   // Output stage and round-robin pointer
   logic                 out_valid_r;
   logic [REG_W-1:0]     out_rd_r;
   logic [DATA_W-1:0]    out_data_r;
   logic [NUM_REQ-1:0]   out_fu_r;
   logic [PTR_W-1:0]     ptr_r;

   // Combinational arbitration terms
   logic                 held_squash_s;
   logic                 load_en_s;
   logic [NUM_REQ-1:0]   elig_s;
   logic                 grant_found_s;
   logic [PTR_W-1:0]     grant_idx_s;
   logic                 grant_s;
   logic [REG_W-1:0]     sel_rd_s;
   logic [DATA_W-1:0]    sel_data_s;
   logic                 sel_rd_nonzero_s;
   logic [PTR_W-1:0]     ptr_next_s;

   // Flush on a held entry from a masked FU kills the write and frees the stage
   always_comb begin
      held_squash_s = flush & (|(flush_mask & out_fu_r));
      wb_valid      = out_valid_r & ~held_squash_s;
      load_en_s     = ~out_valid_r | (wb_valid & wb_ready) | held_squash_s;
      elig_s        = req_valid & ~({NUM_REQ{flush}} & flush_mask);
   end

   // Round-robin pick. The scan runs from the far end of the rotation back to
   // ptr, so the last match kept is the first eligible index at or after ptr.
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = {PTR_W{1'b0}};
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         grant_idx_s   = elig_s[rr_index(ptr_r, unsigned'(k))] ?
                         rr_index(ptr_r, unsigned'(k)) : grant_idx_s;
         grant_found_s = grant_found_s | elig_s[rr_index(ptr_r, unsigned'(k))];
      end
   end

   // Grant qualification. Nothing is accepted while reset is asserted, so
   // no requester loses a result that the reset would discard.
   always_comb begin
      grant_s = ~RST & load_en_s & grant_found_s;
      if (grant_s) begin
         req_ready = fu_onehot(grant_idx_s);
      end else begin
         req_ready = {NUM_REQ{1'b0}};
      end
   end

   // Select the winning FU's destination register and data
   always_comb begin
      sel_rd_s   = {REG_W{1'b0}};
      sel_data_s = {DATA_W{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_rd_s   = (PTR_W'(i) == grant_idx_s) ? req_rd[i*REG_W +: REG_W]    : sel_rd_s;
         sel_data_s = (PTR_W'(i) == grant_idx_s) ? req_data[i*DATA_W +: DATA_W] : sel_data_s;
      end
      sel_rd_nonzero_s = |sel_rd_s;
   end

   // Pointer moves to the slot just past the winner, wrapping at the last FU
   always_comb begin
      if (grant_idx_s == LAST_IDX) begin
         ptr_next_s = {PTR_W{1'b0}};
      end else begin
         ptr_next_s = grant_idx_s + PTR_W'(1'b1);
      end
   end

   // Output stage and pointer update. An x0 winner is consumed and leaves the
   // stage empty. With nothing eligible, the stage empties and ptr holds.
   always_ff @(posedge CLK) begin
      if (RST) begin
         out_valid_r <= 1'b0;
         out_rd_r    <= {REG_W{1'b0}};
         out_data_r  <= {DATA_W{1'b0}};
         out_fu_r    <= {NUM_REQ{1'b0}};
         ptr_r       <= {PTR_W{1'b0}};
      end else if (load_en_s) begin
         if (grant_s && sel_rd_nonzero_s) begin
            out_valid_r <= 1'b1;
            out_rd_r    <= sel_rd_s;
            out_data_r  <= sel_data_s;
            out_fu_r    <= fu_onehot(grant_idx_s);
         end else begin
            out_valid_r <= 1'b0;
            out_rd_r    <= {REG_W{1'b0}};
            out_data_r  <= {DATA_W{1'b0}};
            out_fu_r    <= {NUM_REQ{1'b0}};
         end
         if (grant_s) begin
            ptr_r <= ptr_next_s;
         end else begin
            ptr_r <= ptr_r;
         end
      end else begin
         out_valid_r <= out_valid_r;
         out_rd_r    <= out_rd_r;
         out_data_r  <= out_data_r;
         out_fu_r    <= out_fu_r;
         ptr_r       <= ptr_r;
      end
   end

   // Write-port payload comes straight from the output registers
   always_comb begin
      wb_rd   = out_rd_r;
      wb_data = out_data_r;
      wb_fu   = out_fu_r;
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Directed, self-checking bench for wb_port_arbiter.
//
// Expected writebacks are queued when the matching grant is driven. A
// monitor on the falling clock edge pops the queue on every transfer
// (wb_valid & wb_ready) and compares rd, data and FU against the queued
// entry. Grants and held-stage state are checked directly in each scenario.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;
   localparam int NUM_REQ = 5;
   localparam int REG_W   = 5;
   localparam int DATA_W  = 32;

   logic                      CLK;
   logic                      RST;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*REG_W-1:0]  req_rd;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      flush;
   logic [NUM_REQ-1:0]        flush_mask;
   logic                      wb_valid;
   logic                      wb_ready;
   logic [REG_W-1:0]          wb_rd;
   logic [DATA_W-1:0]         wb_data;
   logic [NUM_REQ-1:0]        wb_fu;

   typedef struct packed {
      logic [REG_W-1:0]   rd;
      logic [DATA_W-1:0]  data;
      logic [NUM_REQ-1:0] fu;
   } wb_entry_t;

   wb_entry_t exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   wb_port_arbiter #(.NUM_REQ(NUM_REQ), .REG_W(REG_W), .DATA_W(DATA_W)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .req_valid  (req_valid),
      .req_rd     (req_rd),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .flush      (flush),
      .flush_mask (flush_mask),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .wb_fu      (wb_fu)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic push_exp(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] data, input int fu_idx);
      wb_entry_t e;
      e.rd   = rd;
      e.data = data;
      e.fu   = 5'b00001 << fu_idx;
      exp_q.push_back(e);
   endtask

   task automatic set_req(input int i, input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] data);
      req_valid[i]                = 1'b1;
      req_rd[i*REG_W +: REG_W]    = rd;
      req_data[i*DATA_W +: DATA_W] = data;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Scoreboard: every transfer must match the oldest expected write
   always @(negedge CLK) begin
      wb_entry_t e;
      if (!RST && wb_valid === 1'b1 && wb_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("wb_unexpected", 64'(wb_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("wb_rd",   64'(wb_rd),   64'(e.rd));
            check_eq("wb_data", 64'(wb_data), 64'(e.data));
            check_eq("wb_fu",   64'(wb_fu),   64'(e.fu));
         end
      end
   end

   initial begin
      int g;
      RST        = 1'b1;
      req_valid  = 5'b00000;
      req_rd     = '0;
      req_data   = '0;
      flush      = 1'b0;
      flush_mask = 5'b00000;
      wb_ready   = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         set_req(i, 5'(i + 1), 32'hA000_0000 + 32'(i));
      end

      // Reset with every FU requesting
      tick();
      check_eq("rst_ready",    64'(req_ready), 64'd0);
      check_eq("rst_wb_valid", 64'(wb_valid),  64'd0);
      tick();
      check_eq("rst_ready2",   64'(req_ready), 64'd0);
      check_eq("rst_wb_valid2", 64'(wb_valid), 64'd0);
      check_eq("rst_wb_rd",    64'(wb_rd),     64'd0);
      check_eq("rst_wb_data",  64'(wb_data),   64'd0);
      check_eq("rst_wb_fu",    64'(wb_fu),     64'd0);
      RST = 1'b0;
      #1;

      // Round-robin wrap: FU0..4 then FU0 again, one per cycle, no bubbles
      for (int k = 0; k < 6; k++) begin
         g = k % NUM_REQ;
         check_eq("rr_grant", 64'(req_ready), 64'(5'b00001 << g));
         if (k > 0) begin
            check_eq("rr_no_bubble", 64'(wb_valid), 64'd1);
         end
         if (k == 1) begin
            check_eq("rr_first_rd", 64'(wb_rd), 64'd1);
         end
         push_exp(5'(g + 1), 32'hA000_0000 + 32'(g), g);
         tick();
      end
      req_valid = 5'b00000;
      tick();
      check_eq("rr_drain", 64'(wb_valid), 64'd0);

      // Back-pressure: pointer is at 1; hold rd=7 for three stalled cycles
      wb_ready = 1'b0;
      set_req(1, 5'd7, 32'h0000_0077);
      #1;
      check_eq("bp_grant", 64'(req_ready), 64'h02);
      push_exp(5'd7, 32'h0000_0077, 1);
      tick();
      req_valid = 5'b00000;
      set_req(3, 5'd3, 32'h0000_0033);
      for (int k = 0; k < 3; k++) begin
         #1;
         check_eq("bp_hold_valid", 64'(wb_valid),  64'd1);
         check_eq("bp_hold_rd",    64'(wb_rd),     64'd7);
         check_eq("bp_hold_ready", 64'(req_ready), 64'd0);
         tick();
      end
      wb_ready = 1'b1;
      #1;
      check_eq("bp_handoff", 64'(req_ready), 64'h08);
      push_exp(5'd3, 32'h0000_0033, 3);
      tick();
      req_valid = 5'b00000;
      tick();

      // x0 drop: pointer is at 4; FU2 writes x0 and the pointer moves to 3
      set_req(2, 5'd0, 32'h0000_DEAD);
      #1;
      check_eq("x0_ready", 64'(req_ready), 64'h04);
      tick();
      req_valid = 5'b00000;
      #1;
      check_eq("x0_no_write", 64'(wb_valid), 64'd0);
      set_req(1, 5'd11, 32'h0000_000B);
      set_req(3, 5'd13, 32'h0000_000D);
      set_req(4, 5'd14, 32'h0000_000E);
      #1;
      check_eq("x0_ptr_at_3", 64'(req_ready), 64'h08);
      push_exp(5'd13, 32'h0000_000D, 3);
      tick();
      req_valid[3] = 1'b0;
      #1;
      check_eq("x0_next_fu4", 64'(req_ready), 64'h10);
      push_exp(5'd14, 32'h0000_000E, 4);
      tick();
      req_valid[4] = 1'b0;
      #1;
      check_eq("x0_wrap_fu1", 64'(req_ready), 64'h02);
      push_exp(5'd11, 32'h0000_000B, 1);
      tick();
      req_valid = 5'b00000;
      tick();

      // Flush beats wb_ready on a masked held entry; FU3 reloads the same cycle
      wb_ready = 1'b0;
      set_req(1, 5'd9, 32'h0000_0099);
      #1;
      check_eq("fl_setup", 64'(req_ready), 64'h02);
      tick();
      req_valid  = 5'b00000;
      set_req(3, 5'd4, 32'h0000_0044);
      flush      = 1'b1;
      flush_mask = 5'b00010;
      wb_ready   = 1'b1;
      #1;
      check_eq("fl_squash", 64'(wb_valid),  64'd0);
      check_eq("fl_reload", 64'(req_ready), 64'h08);
      push_exp(5'd4, 32'h0000_0044, 3);
      tick();
      flush      = 1'b0;
      flush_mask = 5'b00000;
      req_valid  = 5'b00000;
      #1;
      check_eq("fl_valid", 64'(wb_valid), 64'd1);
      check_eq("fl_rd",    64'(wb_rd),    64'd4);
      check_eq("fl_fu",    64'(wb_fu),    64'h08);
      tick();

      // Flush gating of requests: bring the pointer to 0 via an FU4 grant
      set_req(4, 5'd20, 32'h0000_0020);
      #1;
      check_eq("fg_setup", 64'(req_ready), 64'h10);
      push_exp(5'd20, 32'h0000_0020, 4);
      tick();
      set_req(0, 5'd22, 32'h0000_0022);
      set_req(4, 5'd21, 32'h0000_0021);
      flush      = 1'b1;
      flush_mask = 5'b00001;
      #1;
      check_eq("fg_unmasked_held", 64'(wb_valid),  64'd1);
      check_eq("fg_grant_fu4",     64'(req_ready), 64'h10);
      push_exp(5'd21, 32'h0000_0021, 4);
      tick();
      flush        = 1'b0;
      flush_mask   = 5'b00000;
      req_valid[4] = 1'b0;
      #1;
      check_eq("fg_late_fu0", 64'(req_ready), 64'h01);
      push_exp(5'd22, 32'h0000_0022, 0);
      tick();
      req_valid = 5'b00000;
      tick();

      // Reset mid-operation discards a held entry
      wb_ready = 1'b0;
      set_req(2, 5'd5, 32'h0000_0055);
      #1;
      check_eq("rm_grant", 64'(req_ready), 64'h04);
      tick();
      req_valid = 5'b00000;
      set_req(3, 5'd6, 32'h0000_0066);
      #1;
      check_eq("rm_held", 64'(wb_valid), 64'd1);
      RST      = 1'b1;
      wb_ready = 1'b1;
      #1;
      check_eq("rm_ready_in_rst", 64'(req_ready), 64'd0);
      tick();
      check_eq("rm_cleared", 64'(wb_valid), 64'd0);
      RST       = 1'b0;
      req_valid = 5'b00000;
      tick();
      check_eq("rm_idle", 64'(wb_valid), 64'd0);

      check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Round-robin arbiter that shares the single scalar register-file write port among NUM_REQ functional-unit writeback requesters: ALU, branch, LSU, MLS and GEMM-status.
- Registers the winning request into a one-entry output stage that feeds the scoreboard writeback path.
- Supports back-pressure from the scoreboard and a branch-miss flush that squashes wrong-path writebacks.

Parameters:
- NUM_REQ, 5, number of writeback requesters; one-hot FU encoding matches fu_ex width.
- REG_W, 5, register index width.
- DATA_W, 32, writeback data width (word_t).

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-FU writeback request.
- req_rd  input  NUM_REQ*REG_W  per-FU destination register, packed; FU i at [i*REG_W +: REG_W].
- req_data  input  NUM_REQ*DATA_W  per-FU writeback data, packed likewise.
- req_ready  output  NUM_REQ  per-FU accept (grant) this cycle.
- flush  input  1  branch-miss squash, single cycle.
- flush_mask  input  NUM_REQ  FUs whose in-flight results are squashed when flush=1.
- wb_valid  output  1  write-port request to scoreboard/regfile.
- wb_ready  input  1  scoreboard accepts the write this cycle.
- wb_rd  output  REG_W  destination register.
- wb_data  output  DATA_W  write data.
- wb_fu  output  NUM_REQ  one-hot source FU of the current write.

Behaviour:
- State:
  - out_valid, out_rd, out_data, out_fu: output stage.
  - ptr: round-robin pointer, range 0..NUM_REQ-1.
- Reset (RST high at CLK edge): out_valid=0, out_rd=0, out_data=0, out_fu=0, ptr=0.
  - Therefore wb_valid=0, wb_rd=0, wb_data=0, wb_fu=0, req_ready=0.
  - Reset mid-operation discards any held entry; no partial write is emitted.
- Output gating: wb_valid = out_valid AND NOT(flush AND |(flush_mask & out_fu)). wb_rd, wb_data and wb_fu come directly from the output registers.
- Transfer: a write occurs only in a cycle where wb_valid=1 and wb_ready=1.
- Load enable: load_en = NOT out_valid OR (wb_valid AND wb_ready) OR (flush AND |(flush_mask & out_fu)).
- Eligibility: elig[i] = req_valid[i] AND NOT(flush AND flush_mask[i]).
- Grant:
  - When load_en=1 and elig is nonzero, grant the first eligible index scanning ptr, ptr+1, … with wrap modulo NUM_REQ.
  - req_ready is one-hot on that index and zero otherwise.
  - Grant is combinational in the same cycle. req_ready may depend on req_valid, but a requester must not make req_valid depend on req_ready.
- On grant of index g at the CLK edge:
  - If req_rd[g] != 0: out_valid=1, out_rd=req_rd[g], out_data=req_data[g], out_fu=one-hot(g).
  - If req_rd[g] == 0 (x0 write): the request is consumed (req_ready=1), out_valid=0, and nothing is emitted.
  - In both cases ptr = (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- load_en=1 with no eligible request: out_valid clears to 0 and ptr is unchanged.
- load_en=0 (holding, scoreboard stalled): the output registers and ptr hold, and all req_ready=0.
- Latency: request accepted in cycle N appears on wb_* in cycle N+1. Throughput is one write per cycle under continuous wb_ready=1; the write-then-reload in the same cycle is a bubble-free handoff.
- Fairness: any continuously asserted requester is granted within NUM_REQ grants.
- Flush and wb_ready in the same cycle on a masked held entry: flush wins. wb_valid is 0 that cycle, the entry is dropped, and the stage may reload from an unmasked requester that same cycle.
- Unmasked held entries are unaffected by flush.
- Requesters are responsible for holding req_valid, req_rd and req_data stable until req_ready.

Test Plan:
- Reset then idle: assert RST 2 cycles with all req_valid=1 → wb_valid=0, req_ready=0 during reset. First grant after deassert is FU0; wb_rd shows FU0's rd one cycle later.
- Round-robin wrap: all 5 FUs hold req_valid with rd=1..5, wb_ready=1 → grants FU0,1,2,3,4,0,… one per cycle. wb_rd sequence is 1,2,3,4,5,1 with no bubbles.
- Back-pressure: one valid entry with rd=7, wb_ready=0 for 3 cycles → wb_valid=1, wb_rd=7 held, req_ready=0, ptr frozen. Raising wb_ready transfers the entry and grants the next FU the same cycle.
- x0 drop: FU2 requests rd=0, data=0xDEAD → req_ready[2]=1, wb_valid=0 next cycle, and ptr advances to 3.
- Flush: held entry from FU1 (rd=9) with flush=1, flush_mask=00010, wb_ready=1, and FU3 valid rd=4 → wb_valid=0 that cycle. Next cycle wb_rd=4, wb_fu=01000.
- Flush gating of requests: FU0 and FU4 valid, flush=1, flush_mask=00001, ptr=0 → FU4 granted and FU0 not granted. FU0 is granted later once flush drops.
